// File: rtl/scan_test_pkg.sv
// Shared definitions for the scan-test sequencer: controller state encoding.
// The pattern record is declared in scan_test_ctrl because its field widths
// follow that module's CHAIN_LEN / PI_W / PO_W parameters.
package scan_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // States in which the sequencer is working through a run.
  function automatic logic state_is_busy(input state_e s);
    return (s == ST_WAIT) || (s == ST_SHIFT) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/scan_pat_buf.sv
// One-entry valid/ready pattern buffer. Accepts only while empty and enabled;
// the controller empties it with a pop when it moves the entry to its active
// register. Fill and pop never coincide because ready requires an empty buffer.
module scan_pat_buf #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  input  logic i_pop,
  output logic o_full,
  output T     o_data
);

  logic r_full;
  T     r_data;

  assign o_ready = i_en && !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;

  // Capture a pattern on handshake; release the slot on pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: loads each buffered pattern into the scan chain, applies
// one functional capture cycle, then unloads the captured state, overlapping
// the unload with the next load when that pattern is already buffered.
// Unloaded state and captured PO are compared with the expected values.
module scan_test_ctrl
  import scan_test_pkg::*;
#(
  parameter int CHAIN_LEN = 3,
  parameter int PI_W      = 1,
  parameter int PO_W      = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_scan,
  input  logic [PI_W-1:0]      pat_pi,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  input  logic [PO_W-1:0]      pat_exp_po,
  input  logic                 pat_last,
  output logic                 scan_enable,
  output logic                 scan_in,
  output logic [PI_W-1:0]      pi,
  input  logic                 scan_out,
  input  logic [PO_W-1:0]      po,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 fail_any,
  output logic [CNT_W-1:0]     first_fail_idx
);

  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef struct packed {
    logic [CHAIN_LEN-1:0] scan;
    logic [PI_W-1:0]      pi;
    logic [CHAIN_LEN-1:0] exp;
    logic [PO_W-1:0]      exp_po;
    logic                 last;
  } pat_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_load;
  logic                 r_unload;
  pat_t                 r_act;
  logic [CHAIN_LEN-1:0] r_unl;
  logic [CHAIN_LEN-1:0] r_rsp_exp;
  logic                 r_rsp_po_mis;
  logic                 r_rsp_last;
  logic [CNT_W-1:0]     r_rsp_idx;
  logic [CNT_W-1:0]     r_pat_idx;
  logic                 r_cmp_pend;
  logic                 r_last_acc;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic                 r_fail_any;
  logic [CNT_W-1:0]     r_first_idx;

  pat_t                 w_in_pat;
  pat_t                 w_buf_data;
  logic                 w_buf_full;
  logic                 w_buf_en;
  logic                 w_pop;
  logic [CW-1:0]        w_sh_idx;
  logic                 w_cnt_last;
  logic                 w_start_ok;
  logic                 w_mis;

  assign w_in_pat   = '{scan: pat_scan, pi: pat_pi, exp: pat_exp,
                        exp_po: pat_exp_po, last: pat_last};
  // No acceptance outside a run, nor after the run's final pattern.
  assign w_buf_en   = (r_state != ST_IDLE) && (r_state != ST_DONE) && !r_last_acc;
  assign w_pop      = ((r_state == ST_WAIT) && w_buf_full) ||
                      ((r_state == ST_CAPTURE) && w_buf_full && !r_act.last);
  // Chain bit addressed on this shift cycle: MSB first, so it lands in flop
  // CHAIN_LEN-1 after the final shift; unload sees flop CHAIN_LEN-1 first too.
  assign w_sh_idx   = CW'(CHAIN_LEN - 1) - r_cnt;
  assign w_cnt_last = (r_cnt == CW'(CHAIN_LEN - 1));
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_mis      = (r_unl != r_rsp_exp) || r_rsp_po_mis;

  scan_pat_buf #(.T(pat_t)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_buf_en),
    .i_valid (pat_valid),
    .o_ready (pat_ready),
    .i_data  (w_in_pat),
    .i_pop   (w_pop),
    .o_full  (w_buf_full),
    .o_data  (w_buf_data)
  );

  assign scan_enable    = (r_state == ST_SHIFT);
  assign scan_in        = (r_state == ST_SHIFT) && r_load && r_act.scan[w_sh_idx];
  assign pi             = r_act.pi;
  assign busy           = state_is_busy(r_state);
  assign done           = (r_state == ST_DONE);
  assign fail_cnt       = r_fail_cnt;
  assign fail_any       = r_fail_any;
  assign first_fail_idx = r_first_idx;

  // Sequencing: load/capture/unload state machine plus response bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_load       <= 1'b0;
      r_unload     <= 1'b0;
      r_act        <= '0;
      r_unl        <= '0;
      r_rsp_exp    <= '0;
      r_rsp_po_mis <= 1'b0;
      r_rsp_last   <= 1'b0;
      r_rsp_idx    <= '0;
      r_pat_idx    <= '0;
      r_cmp_pend   <= 1'b0;
      r_last_acc   <= 1'b0;
    end else begin
      r_cmp_pend <= 1'b0;
      if (pat_valid && pat_ready && pat_last) r_last_acc <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_WAIT;
            r_pat_idx  <= '0;
            r_last_acc <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_buf_full) begin
            r_state  <= ST_SHIFT;
            r_act    <= w_buf_data;
            r_load   <= 1'b1;
            r_unload <= 1'b0;
            r_cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          if (r_unload) r_unl[w_sh_idx] <= scan_out;
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_unload) r_cmp_pend <= 1'b1;
            if (r_load)          r_state <= ST_CAPTURE;
            else if (r_rsp_last) r_state <= ST_DONE;
            else                 r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_CAPTURE: begin
          r_rsp_exp    <= r_act.exp;
          r_rsp_po_mis <= (po != r_act.exp_po);
          r_rsp_last   <= r_act.last;
          r_rsp_idx    <= r_pat_idx;
          r_pat_idx    <= r_pat_idx + CNT_W'(1);
          r_state      <= ST_SHIFT;
          r_unload     <= 1'b1;
          r_cnt        <= '0;
          if (w_pop) begin
            r_act  <= w_buf_data;
            r_load <= 1'b1;
          end else begin
            r_load <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result accumulation: one cycle after a pattern's final unload shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fail_cnt  <= '0;
      r_fail_any  <= 1'b0;
      r_first_idx <= '0;
    end else if (w_start_ok) begin
      r_fail_cnt  <= '0;
      r_fail_any  <= 1'b0;
      r_first_idx <= '0;
    end else if (r_cmp_pend && w_mis) begin
      r_fail_cnt <= sat_inc(r_fail_cnt);
      r_fail_any <= 1'b1;
      if (!r_fail_any) r_first_idx <= r_rsp_idx;
    end
  end

endmodule
